// File: rtl/mem_access.sv
// Memory-stage access controller: handshakes loads/stores with a single-beat bus, stalls the pipeline
// and extracts/extends load data. Optional bus timeout is enabled with `define MEM_ACCESS_TIMEOUT_EN.
module mem_access (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        iMemRead,
  input  logic        iMemWrite,
  input  logic [31:0] iIR,
  input  logic [31:0] iResult,
  input  logic [31:0] iB,
  output logic [31:0] oReadData,
  output logic        oStall,
  output logic        oMisalign,
  output logic        oBusErr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;

  function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << lane;
      SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] replicate_store(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] wd;
    case (size)
      SZ_BYTE: wd = {4{data[7:0]}};
      SZ_HALF: wd = {2{data[15:0]}};
      default: wd = data;
    endcase
    return wd;
  endfunction

  function automatic logic [31:0] extract_load(input logic [1:0] size, input logic uns,
                                               input logic [1:0] lane, input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] rd;
    case (lane)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      2'd3:    b = rdata[31:24];
      default: b = rdata[7:0];
    endcase
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: rd = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      SZ_HALF: rd = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: rd = rdata;
    endcase
    return rd;
  endfunction

  state_t      state_r, state_next_s;
  logic        access_s, is_store_s, misalign_s, stall_s, timeout_hit_s;
  logic [1:0]  size_s, lane_s;
  logic        unsigned_s;
  logic [5:0]  opcode_s;
  logic        unused_s;

  logic        mem_req_r, mem_we_r, misalign_r;
  logic [31:0] mem_addr_r, mem_wdata_r, read_data_r;
  logic [3:0]  mem_be_r;
  logic [1:0]  size_r, lane_r;
  logic        unsigned_r;

  assign opcode_s = iIR[31:26];
  assign lane_s   = iResult[1:0];
  assign unused_s = ^iIR[25:0];

  // Decode access size/signedness; a simultaneous read and write is treated as a store.
  always_comb begin
    access_s   = iMemRead | iMemWrite;
    is_store_s = iMemWrite;
    size_s     = SZ_WORD;
    unsigned_s = 1'b0;
    if (is_store_s) begin
      case (opcode_s)
        OP_SB:   size_s = SZ_BYTE;
        OP_SH:   size_s = SZ_HALF;
        default: size_s = SZ_WORD;
      endcase
    end else begin
      case (opcode_s)
        OP_LB:   size_s = SZ_BYTE;
        OP_LBU:  begin size_s = SZ_BYTE; unsigned_s = 1'b1; end
        OP_LH:   size_s = SZ_HALF;
        OP_LHU:  begin size_s = SZ_HALF; unsigned_s = 1'b1; end
        default: size_s = SZ_WORD;
      endcase
    end
    misalign_s = access_s && (((size_s == SZ_HALF) && lane_s[0]) ||
                              ((size_s == SZ_WORD) && (lane_s != 2'd0)));
  end

  // Next-state and stall generation.
  always_comb begin
    state_next_s = state_r;
    stall_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (access_s && !misalign_s) begin
          stall_s      = 1'b1;
          state_next_s = ACCESS;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACCESS: begin
        stall_s = 1'b1;
        if (mem_ack || timeout_hit_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = ACCESS;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Bus request fields, misalign pulse and load-data capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_be_r    <= 4'h0;
      mem_addr_r  <= 32'h0000_0000;
      mem_wdata_r <= 32'h0000_0000;
      read_data_r <= 32'h0000_0000;
      misalign_r  <= 1'b0;
      size_r      <= SZ_WORD;
      lane_r      <= 2'd0;
      unsigned_r  <= 1'b0;
    end else begin
      misalign_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (access_s && misalign_s) begin
            misalign_r  <= 1'b1;
            read_data_r <= 32'h0000_0000;
          end else if (access_s) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= is_store_s;
            mem_be_r    <= lane_enables(size_s, lane_s);
            mem_addr_r  <= {iResult[31:2], 2'b00};
            mem_wdata_r <= replicate_store(size_s, iB);
            size_r      <= size_s;
            lane_r      <= lane_s;
            unsigned_r  <= unsigned_s;
          end else begin
            mem_req_r <= 1'b0;
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            if (!mem_we_r) begin
              read_data_r <= extract_load(size_r, unsigned_r, lane_r, mem_rdata);
            end
            mem_req_r <= 1'b0;
            mem_we_r  <= 1'b0;
            mem_be_r  <= 4'h0;
          end else if (timeout_hit_s) begin
            read_data_r <= 32'h0000_0000;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_be_r    <= 4'h0;
          end else begin
            mem_req_r <= 1'b1;
          end
        end
        default: mem_req_r <= 1'b0;
      endcase
    end
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  logic [7:0] timeout_cnt_r;
  logic       bus_err_r;

  assign timeout_hit_s = (state_r == ACCESS) && !mem_ack && (timeout_cnt_r == 8'd254);

  // Counts un-acknowledged ACCESS cycles; zero whenever not waiting.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timeout_cnt_r <= 8'd0;
    end else if ((state_r == ACCESS) && !mem_ack) begin
      timeout_cnt_r <= timeout_cnt_r + 8'd1;
    end else begin
      timeout_cnt_r <= 8'd0;
    end
  end

  // Bus error is high exactly during the DONE cycle reached by timeout.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus_err_r <= 1'b0;
    end else begin
      bus_err_r <= timeout_hit_s;
    end
  end

  assign oBusErr = bus_err_r;
`else
  assign timeout_hit_s = 1'b0;
  assign oBusErr       = 1'b0;
`endif

  assign oStall    = stall_s;
  assign oMisalign = misalign_r;
  assign oReadData = read_data_r;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_be    = mem_be_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

endmodule
